// File: rtl/line_drawer_core.sv
// line_drawer_core: Bresenham rasterizer emitting one registered on-line pixel per clock.
module line_drawer_core #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         done
);
    typedef enum logic [1:0] {LOAD, DRAW, DONE} state_t;
    state_t state, state_n;
    logic [W-1:0] x_n, y_n, xe, ye, xe_n, ye_n;
    logic done_n, sx_neg, sy_neg, sx_n, sy_n, step_x, step_y;
    logic signed [W+1:0] dx, dy, dx_n, dy_n, dxs, dys, ax, ay;
    // err spans roughly [2*dy, 2*dx]; one extra bit over dx keeps it and e2 overflow-free
    logic signed [W+2:0] err, err_n;
    logic signed [W+3:0] e2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= LOAD;
            x      <= '0;
            y      <= '0;
            done   <= 1'b0;
            err    <= '0;
            dx     <= '0;
            dy     <= '0;
            xe     <= '0;
            ye     <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else begin
            state  <= state_n;
            x      <= x_n;
            y      <= y_n;
            done   <= done_n;
            err    <= err_n;
            dx     <= dx_n;
            dy     <= dy_n;
            xe     <= xe_n;
            ye     <= ye_n;
            sx_neg <= sx_n;
            sy_neg <= sy_n;
        end
    end

    always_comb begin
        dxs     = $signed({2'b00, x1}) - $signed({2'b00, x0});
        dys     = $signed({2'b00, y1}) - $signed({2'b00, y0});
        e2      = {err, 1'b0};
        step_x  = e2 >= dy;
        step_y  = e2 <= dx;
        ax      = step_x ? dy : '0;
        ay      = step_y ? dx : '0;
        state_n = state;
        x_n     = x;
        y_n     = y;
        done_n  = done;
        err_n   = err;
        dx_n    = dx;
        dy_n    = dy;
        xe_n    = xe;
        ye_n    = ye;
        sx_n    = sx_neg;
        sy_n    = sy_neg;
        if (state == LOAD) begin
            xe_n    = x1;
            ye_n    = y1;
            dx_n    = dxs[W+1] ? -dxs : dxs;
            dy_n    = dys[W+1] ? dys : -dys;
            sx_n    = !(x0 < x1);
            sy_n    = !(y0 < y1);
            err_n   = dx_n + dy_n;
            x_n     = x0;
            y_n     = y0;
            done_n  = (x0 == x1) && (y0 == y1);
            state_n = done_n ? DONE : DRAW;
        end else if (state == DRAW) begin
            x_n     = step_x ? x + (sx_neg ? {W{1'b1}} : W'(1)) : x;
            y_n     = step_y ? y + (sy_neg ? {W{1'b1}} : W'(1)) : y;
            err_n   = err + ax + ay;
            done_n  = (x_n == xe) && (y_n == ye);
            state_n = done_n ? DONE : DRAW;
        end
    end
endmodule

// File: tb/tb_line_drawer_core.sv
// tb_line_drawer_core: scoreboard bench for line_drawer_core; expected pixels queued, popped per cycle.
module tb_line_drawer_core;
    localparam int W = 11;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [W-1:0] x, y;
    logic done;
    int errors = 0;
    int checks = 0;
    logic [2*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    line_drawer_core #(.W(W)) dut (
        .clk(clk), .reset(reset), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .x(x), .y(y), .done(done)
    );

    task automatic push(input int px, input int py);
        exp_q.push_back({px[W-1:0], py[W-1:0]});
    endtask

    task automatic start(input int a, input int b, input int c, input int d);
        x0 = a[W-1:0];
        y0 = b[W-1:0];
        x1 = c[W-1:0];
        y1 = d[W-1:0];
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        logic [2*W-1:0] e;
        logic last;
        e = '0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            last = (exp_q.size() == 0);
            checks++;
            if ({x, y} !== e) begin
                errors++;
                $display("FAIL %s pixel: got (%0d,%0d) expected (%0d,%0d)", name, x, y, e[2*W-1:W], e[W-1:0]);
            end
            checks++;
            if (done !== last) begin
                errors++;
                $display("FAIL %s done at (%0d,%0d): got %b expected %b", name, x, y, done, last);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({x, y, done} !== {e, 1'b1}) begin
            errors++;
            $display("FAIL %s hold: got (%0d,%0d) done=%b expected (%0d,%0d) done=1", name, x, y, done, e[2*W-1:W], e[W-1:0]);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({x, y, done} !== {{(2*W){1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset: got (%0d,%0d) done=%b expected (0,0) done=0", x, y, done);
        end
    endtask

    task automatic test_diagonal();
        for (int k = 0; k <= 240; k++) push(k, k);
        start(0, 0, 240, 240);
        drain("diagonal");
    endtask

    task automatic test_shallow();
        int tx[5] = '{0, 1, 2, 3, 4};
        int ty[5] = '{0, 1, 1, 2, 2};
        for (int i = 0; i < 5; i++) push(tx[i], ty[i]);
        start(0, 0, 4, 2);
        drain("shallow");
    endtask

    task automatic test_vertical();
        for (int v = 40; v >= 30; v--) push(30, v);
        start(30, 40, 30, 30);
        drain("vertical");
    endtask

    task automatic test_horizontal();
        logic [2*W-1:0] e;
        for (int v = 20; v >= 10; v--) push(v, 50);
        start(20, 50, 10, 50);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({x, y} !== e) begin
            errors++;
            $display("FAIL horizontal first: got (%0d,%0d) expected (20,50)", x, y);
        end
        x0 = 0;
        y0 = 0;
        x1 = 100;
        y1 = 7;
        drain("horizontal");
    endtask

    task automatic test_degenerate();
        push(70, 70);
        start(70, 70, 70, 70);
        drain("degenerate");
    endtask

    task automatic test_mid_reset();
        int n;
        start(0, 0, 240, 240);
        repeat (101) @(negedge clk);
        checks++;
        if ({x, y, done} !== {11'd100, 11'd100, 1'b0}) begin
            errors++;
            $display("FAIL midreset pre: got (%0d,%0d) done=%b expected (100,100) done=0", x, y, done);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({x, y, done} !== {{(2*W){1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL midreset async: got (%0d,%0d) done=%b expected (0,0) done=0", x, y, done);
        end
        x0 = 10;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({x, y, done} !== {11'd10, 11'd0, 1'b0}) begin
            errors++;
            $display("FAIL midreset restart: got (%0d,%0d) done=%b expected (10,0) done=0", x, y, done);
        end
        n = 1;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 241) begin
            errors++;
            $display("FAIL midreset count: got %0d pixels expected 241", n);
        end
        checks++;
        if ({x, y, done} !== {11'd240, 11'd240, 1'b1}) begin
            errors++;
            $display("FAIL midreset end: got (%0d,%0d) done=%b expected (240,240) done=1", x, y, done);
        end
    endtask

    initial begin
        test_reset();
        test_diagonal();
        test_shallow();
        test_vertical();
        test_horizontal();
        test_degenerate();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
